full_adder: RTL and testbench



---
 rtl/full_adder_pkg.sv | 10 +
 rtl/full_adder_if.sv | 23 ++
 rtl/full_adder_fa_bit.sv | 15 +
 rtl/full_adder.sv | 52 +++++
 tb/tb_full_adder.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/full_adder_pkg.sv
// Shared helpers for the full_adder slice: the bit-level carry function used
// by every cell of the ripple chain.
package full_adder_pkg;

  // Majority of three inputs: the carry-out of a 1-bit full adder.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle of the clocked full adder; the producer drives the
// operands through master, the adder sits on slave.
interface full_adder_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             out_valid;

  modport master (
    output in_valid, A, B, Cin,
    input  S, Cout, out_valid
  );

  modport slave (
    input  in_valid, A, B, Cin,
    output S, Cout, out_valid
  );
endinterface

// File: rtl/full_adder_fa_bit.sv
// Purely combinational 1-bit full adder cell; one link of the ripple chain.
module fa_bit
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = maj3(a, b, ci);

endmodule

// File: rtl/full_adder.sv
// Clocked WIDTH-bit full adder: ripple chain of fa_bit cells feeding one
// register stage for {Cout, S} plus a one-cycle valid flag. WIDTH is 1..64.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  full_adder_if.slave  bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;
  logic             out_valid_reg;

  assign carry[0] = bus.Cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
      fa_bit u_bit (
        .a  (bus.A[gi]),
        .b  (bus.B[gi]),
        .ci (carry[gi]),
        .s  (sum_next[gi]),
        .co (carry[gi+1])
      );
    end
  endgenerate

  // Reset wins over a same-edge capture; idle cycles keep the last result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_reg         <= '0;
      cout_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s_reg    <= sum_next;
        cout_reg <= carry[WIDTH];
      end
    end
  end

  assign bus.S         = s_reg;
  assign bus.Cout      = cout_reg;
  assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench: three adders (WIDTH 1, 8, 16) driven in lockstep,
// directed expectations plus a "last accepted A+B+Cin" reference model.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  full_adder_if #(.WIDTH(1))  if1 ();
  full_adder_if #(.WIDTH(8))  if8 ();
  full_adder_if #(.WIDTH(16)) if16 ();

  full_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  full_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  full_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  int vectors = 0;
  int miscompares = 0;

  // Reference: result of the most recent accepted operation, and valid flag.
  logic [1:0]  m1;
  logic [8:0]  m8;
  logic [16:0] m16;
  logic        mv1, mv8, mv16;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rnd_all(input logic v);
    if1.in_valid = v;  if1.A = 1'($urandom);  if1.B = 1'($urandom);  if1.Cin = 1'($urandom);
    if8.in_valid = v;  if8.A = 8'($urandom);  if8.B = 8'($urandom);  if8.Cin = 1'($urandom);
    if16.in_valid = v; if16.A = 16'($urandom); if16.B = 16'($urandom); if16.Cin = 1'($urandom);
  endtask

  task automatic set_all(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c);
    if1.in_valid = v;  if1.A = a[0:0];  if1.B = b[0:0];  if1.Cin = c;
    if8.in_valid = v;  if8.A = a[7:0];  if8.B = b[7:0];  if8.Cin = c;
    if16.in_valid = v; if16.A = a;      if16.B = b;      if16.Cin = c;
  endtask

  // Advance one edge, update the model from what was presented, compare all.
  task automatic tick(input string tag);
    if (!rst_n) begin
      m1 = '0; m8 = '0; m16 = '0; mv1 = 0; mv8 = 0; mv16 = 0;
    end else begin
      mv1 = if1.in_valid; mv8 = if8.in_valid; mv16 = if16.in_valid;
      if (if1.in_valid)  m1  = 2'(if1.A)   + 2'(if1.B)   + 2'(if1.Cin);
      if (if8.in_valid)  m8  = 9'(if8.A)   + 9'(if8.B)   + 9'(if8.Cin);
      if (if16.in_valid) m16 = 17'(if16.A) + 17'(if16.B) + 17'(if16.Cin);
    end
    @(posedge clk);
    #1;
    check({tag, "/w1_sum"},  65'({if1.Cout, if1.S}),   65'(m1));
    check({tag, "/w1_vld"},  65'(if1.out_valid),       65'(mv1));
    check({tag, "/w8_sum"},  65'({if8.Cout, if8.S}),   65'(m8));
    check({tag, "/w8_vld"},  65'(if8.out_valid),       65'(mv8));
    check({tag, "/w16_sum"}, 65'({if16.Cout, if16.S}), 65'(m16));
    check({tag, "/w16_vld"}, 65'(if16.out_valid),      65'(mv16));
  endtask

  logic [7:0] tbl_s    = 8'b1001_0110;
  logic [7:0] tbl_cout = 8'b1110_1000;
  logic [2:0] abc;

  initial begin
    // Reset with every operand asserted: nothing may be captured.
    rst_n = 1'b0;
    set_all(1'b1, 16'h0001, 16'h0001, 1'b1);
    tick("reset0");
    tick("reset1");
    check("reset/S",    65'(if8.S),         65'd0);
    check("reset/Cout", 65'(if8.Cout),      65'd0);
    check("reset/vld",  65'(if1.out_valid), 65'd0);

    // Exhaustive single-bit truth table.
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      rnd_all(1'b1);
      if1.A = abc[2]; if1.B = abc[1]; if1.Cin = abc[0];
      tick("exh");
      check($sformatf("exh%0d/S", i),    65'(if1.S),         65'(tbl_s[i]));
      check($sformatf("exh%0d/Cout", i), 65'(if1.Cout),      65'(tbl_cout[i]));
      check($sformatf("exh%0d/vld", i),  65'(if1.out_valid), 65'd1);
    end

    // Hold: one accept, then three idle cycles with wiggling operands.
    set_all(1'b1, 16'h0001, 16'h0000, 1'b0);
    tick("hold_acc");
    check("hold_acc/vld", 65'(if1.out_valid), 65'd1);
    for (int i = 0; i < 3; i++) begin
      rnd_all(1'b0);
      tick("hold_idle");
      check("hold/S",    65'(if1.S),         65'd1);
      check("hold/Cout", 65'(if1.Cout),      65'd0);
      check("hold/vld",  65'(if1.out_valid), 65'd0);
    end

    // Carry ripple end to end, and MSB-only carry.
    set_all(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    if8.A = 8'hFF;
    tick("ripple1");
    check("ripple1/w8", 65'({if8.Cout, if8.S}), 65'h100);
    check("ripple1/w16", 65'({if16.Cout, if16.S}), 65'h10000);
    set_all(1'b1, 16'h0080, 16'h0080, 1'b0);
    tick("ripple2");
    check("ripple2/w8", 65'({if8.Cout, if8.S}), 65'h100);
    set_all(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    tick("allones");
    check("allones/w16", 65'({if16.Cout, if16.S}), 65'h1FFFF);
    check("allones/w8",  65'({if8.Cout, if8.S}),   65'h1FF);

    // Reset directly after an accept discards that result.
    set_all(1'b1, 16'h0001, 16'h0001, 1'b0);
    tick("mid_acc");
    check("mid_acc/w1", 65'({if1.Cout, if1.S}), 65'b10);
    rst_n = 1'b0;
    rnd_all(1'b1);
    tick("mid_rst");
    check("mid_rst/w16", 65'({if16.Cout, if16.S}), 65'd0);
    check("mid_rst/vld", 65'(if16.out_valid), 65'd0);
    rst_n = 1'b1;
    set_all(1'b1, 16'h0000, 16'h0000, 1'b1);
    tick("post_rst");
    check("post_rst/w1",  65'({if1.Cout, if1.S}),   65'd1);
    check("post_rst/w8",  65'({if8.Cout, if8.S}),   65'd1);
    check("post_rst/vld", 65'(if8.out_valid),       65'd1);

    // Back-to-back random traffic, then random valid gaps.
    for (int i = 0; i < 1000; i++) begin
      rnd_all(1'b1);
      tick("rand");
    end
    for (int i = 0; i < 200; i++) begin
      rnd_all(1'($urandom));
      tick("rand_gap");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
